// File: rtl/sp_ctrl_pkg.sv
// Shared types and widths for the bus-datapath control unit.
package sp_ctrl_pkg;

  localparam int WORD_W = 9;
  localparam int REG_W  = 3;

  typedef enum logic [2:0] {
    OP_MV  = 3'b000,
    OP_MVI = 3'b001,
    OP_ADD = 3'b010,
    OP_SUB = 3'b011
  } opcode_t;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } step_t;

endpackage

// File: rtl/proc_control_unit_if.sv
// Control-unit <-> datapath signal bundle; master = control unit, slave = datapath.
interface proc_control_unit_if;
  import sp_ctrl_pkg::*;

  // Run acts as valid and is accepted only while the controller sits in T0
  // (implicit ready); Done marks the last step of the accepted instruction.
  logic [WORD_W-1:0] Din;
  logic Run;
  logic R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in;
  logic R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out;
  logic Ain, Gin, Gout, Dinout, AddSub, Done;

  modport master (
    input  Din, Run,
    output R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    output R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    output Ain, Gin, Gout, Dinout, AddSub, Done
  );

  modport slave (
    output Din, Run,
    input  R0in, R1in, R2in, R3in, R4in, R5in, R6in, R7in,
    input  R0out, R1out, R2out, R3out, R4out, R5out, R6out, R7out,
    input  Ain, Gin, Gout, Dinout, AddSub, Done
  );

endinterface

// File: rtl/proc_control_unit_dec3to8.sv
// 3-to-8 one-hot decoder with enable; all-zero when disabled.
module dec3to8 (
  input  logic       en,
  input  logic [2:0] sel,
  output logic [7:0] y
);

  assign y = en ? (8'b1 << sel) : 8'b0;

endmodule

// File: rtl/proc_control_unit.sv
// Multi-cycle T0..T3 sequencer for the 9-bit bus datapath.
// Optional macro SP_ILLEGAL_OP_EN adds the sticky illegal_op output.
module proc_control_unit
  import sp_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  proc_control_unit_if.master bus,
`ifdef SP_ILLEGAL_OP_EN
  output logic illegal_op,
`endif
  output step_t dbg_state
);

  step_t             state, next_state;
  logic [WORD_W-1:0] ir;
  logic [2:0]        opcode;
  logic [REG_W-1:0]  rx, ry;

  logic       rx_in_en, rx_out_en, ry_out_en;
  logic       ain, gin, gout, dinout, addsub, done;
  logic [7:0] rin, rx_out, ry_out, rout;

  assign opcode    = ir[8:6];
  assign rx        = ir[5:3];
  assign ry        = ir[2:0];
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= T0;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == T0 && bus.Run) ir <= bus.Din;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      T0: next_state = bus.Run ? T1 : T0;
      T1: next_state = (opcode == OP_ADD || opcode == OP_SUB) ? T2 : T0;
      T2: next_state = T3;
      T3: next_state = T0;
      default: next_state = T0;
    endcase
  end

  // Outputs depend only on registered state and IR, so nothing from Din/Run leaks through.
  always_comb begin
    rx_in_en  = 1'b0;
    rx_out_en = 1'b0;
    ry_out_en = 1'b0;
    ain       = 1'b0;
    gin       = 1'b0;
    gout      = 1'b0;
    dinout    = 1'b0;
    addsub    = 1'b0;
    done      = 1'b0;
    case (state)
      T1: begin
        case (opcode)
          OP_MV: begin
            ry_out_en = 1'b1;
            rx_in_en  = 1'b1;
            done      = 1'b1;
          end
          OP_MVI: begin
            dinout   = 1'b1;
            rx_in_en = 1'b1;
            done     = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            rx_out_en = 1'b1;
            ain       = 1'b1;
          end
          default: done = 1'b1;
        endcase
      end
      T2: begin
        ry_out_en = 1'b1;
        gin       = 1'b1;
        addsub    = (opcode == OP_SUB);
      end
      T3: begin
        gout     = 1'b1;
        rx_in_en = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  dec3to8 u_rx_in  (.en(rx_in_en),  .sel(rx), .y(rin));
  dec3to8 u_rx_out (.en(rx_out_en), .sel(rx), .y(rx_out));
  dec3to8 u_ry_out (.en(ry_out_en), .sel(ry), .y(ry_out));

  // Rx and Ry drive selects are never enabled in the same step.
  assign rout = rx_out | ry_out;

  assign bus.R0in  = rin[0];
  assign bus.R1in  = rin[1];
  assign bus.R2in  = rin[2];
  assign bus.R3in  = rin[3];
  assign bus.R4in  = rin[4];
  assign bus.R5in  = rin[5];
  assign bus.R6in  = rin[6];
  assign bus.R7in  = rin[7];
  assign bus.R0out = rout[0];
  assign bus.R1out = rout[1];
  assign bus.R2out = rout[2];
  assign bus.R3out = rout[3];
  assign bus.R4out = rout[4];
  assign bus.R5out = rout[5];
  assign bus.R6out = rout[6];
  assign bus.R7out = rout[7];
  assign bus.Ain    = ain;
  assign bus.Gin    = gin;
  assign bus.Gout   = gout;
  assign bus.Dinout = dinout;
  assign bus.AddSub = addsub;
  assign bus.Done   = done;

`ifdef SP_ILLEGAL_OP_EN
  always_ff @(posedge clk) begin
    if (rst) illegal_op <= 1'b0;
    else if (state == T1 && opcode[2]) illegal_op <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_proc_control_unit.sv
// Directed table-driven bench for proc_control_unit, plus reset-abort and
// sticky illegal_op sequences.
module tb_proc_control_unit;
  import sp_ctrl_pkg::*;

  localparam logic [5:0] C_DONE   = 6'b000001;
  localparam logic [5:0] C_ADDSUB = 6'b000010;
  localparam logic [5:0] C_DIN    = 6'b000100;
  localparam logic [5:0] C_GOUT   = 6'b001000;
  localparam logic [5:0] C_GIN    = 6'b010000;
  localparam logic [5:0] C_AIN    = 6'b100000;

  typedef struct {
    logic [8:0]  din;
    logic        run;
    logic [21:0] exp_out;
    step_t       exp_state;
  } vec_t;

  logic  clk;
  logic  rst;
  step_t dbg_state;
`ifdef SP_ILLEGAL_OP_EN
  logic  illegal_op;
`endif

  int checks   = 0;
  int failures = 0;
  vec_t vecs[$];

  proc_control_unit_if bus();

  proc_control_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
`ifdef SP_ILLEGAL_OP_EN
    .illegal_op(illegal_op),
`endif
    .dbg_state (dbg_state)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {rin[7:0], rout[7:0], Ain, Gin, Gout, Dinout, AddSub, Done}
  logic [21:0] act;
  assign act = {bus.R7in, bus.R6in, bus.R5in, bus.R4in,
                bus.R3in, bus.R2in, bus.R1in, bus.R0in,
                bus.R7out, bus.R6out, bus.R5out, bus.R4out,
                bus.R3out, bus.R2out, bus.R1out, bus.R0out,
                bus.Ain, bus.Gin, bus.Gout, bus.Dinout, bus.AddSub, bus.Done};

  function automatic logic [21:0] ex(input logic [7:0] rin, input logic [7:0] rout,
                                     input logic [5:0] ctl);
    return {rin, rout, ctl};
  endfunction

  task automatic add_vec(input logic [8:0] din, input logic run,
                         input logic [21:0] e, input step_t s);
    vec_t v;
    v.din = din; v.run = run; v.exp_out = e; v.exp_state = s;
    vecs.push_back(v);
  endtask

  // scoreboard compare of outputs, state and bus invariants
  task automatic chk(input string name, input logic [21:0] e, input step_t s);
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s outputs: got %06h expected %06h", name, act, e);
    end
    checks++;
    if (dbg_state !== s) begin
      failures++;
      $display("FAIL %s state: got %0d expected %0d", name, dbg_state, s);
    end
    checks++;
    if (!$onehot0(act[21:14])) begin
      failures++;
      $display("FAIL %s rin_onehot: got %02h expected at most one bit", name, act[21:14]);
    end
    checks++;
    if (!$onehot0({act[13:6], act[3], act[2]})) begin
      failures++;
      $display("FAIL %s bus_drive_onehot: got %03h expected at most one bit",
               name, {act[13:6], act[3], act[2]});
    end
  endtask

  // driver: apply inputs just after an edge, sample 1 time unit after the next edge
  task automatic step(input string name, input logic [8:0] din, input logic run,
                      input logic [21:0] e, input step_t s);
    bus.Din = din;
    bus.Run = run;
    @(posedge clk);
    #1;
    chk(name, e, s);
  endtask

  initial begin
    rst     = 1'b1;
    bus.Din = '0;
    bus.Run = 1'b0;
    @(posedge clk);
    #1;
    chk("reset", '0, T0);
`ifdef SP_ILLEGAL_OP_EN
    checks++;
    if (illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL reset_illegal_op: got %b expected 0", illegal_op);
    end
`endif
    rst = 1'b0;

    // idle, Din ignored
    for (int i = 0; i < 5; i++)
      add_vec(9'($urandom_range(0, 511)), 1'b0, '0, T0);
    // mvi R2,#5
    add_vec(9'b001_010_000, 1'b1, ex(8'h04, 8'h00, C_DIN | C_DONE), T1);
    add_vec(9'h005,         1'b0, '0, T0);
    // mv R5,R2
    add_vec(9'b000_101_010, 1'b1, ex(8'h20, 8'h04, C_DONE), T1);
    add_vec(9'h000,         1'b0, '0, T0);
    // add R0,R1 with Run/Din garbage in T1..T3
    add_vec(9'b010_000_001, 1'b1, ex(8'h00, 8'h01, C_AIN), T1);
    add_vec(9'h1c0,         1'b1, ex(8'h00, 8'h02, C_GIN), T2);
    add_vec(9'h1c0,         1'b1, ex(8'h01, 8'h00, C_GOUT | C_DONE), T3);
    add_vec(9'h000,         1'b0, '0, T0);
    // sub R7,R7 then back-to-back mv R1,R7 with Run held
    add_vec(9'b011_111_111, 1'b1, ex(8'h00, 8'h80, C_AIN), T1);
    add_vec(9'b000_001_111, 1'b1, ex(8'h00, 8'h80, C_GIN | C_ADDSUB), T2);
    add_vec(9'b000_001_111, 1'b1, ex(8'h80, 8'h00, C_GOUT | C_DONE), T3);
    add_vec(9'b000_001_111, 1'b1, '0, T0);
    add_vec(9'b000_001_111, 1'b1, ex(8'h02, 8'h80, C_DONE), T1);
    add_vec(9'h000,         1'b0, '0, T0);
    // mv R2,R2
    add_vec(9'b000_010_010, 1'b1, ex(8'h04, 8'h04, C_DONE), T1);
    add_vec(9'h000,         1'b0, '0, T0);
    // illegal opcodes 100 and 111 complete as NOPs
    add_vec(9'b100_000_000, 1'b1, ex(8'h00, 8'h00, C_DONE), T1);
    add_vec(9'h000,         1'b0, '0, T0);
    add_vec(9'b111_011_100, 1'b1, ex(8'h00, 8'h00, C_DONE), T1);
    add_vec(9'h000,         1'b0, '0, T0);

    for (int i = 0; i < vecs.size(); i++)
      step($sformatf("vec%0d", i), vecs[i].din, vecs[i].run, vecs[i].exp_out, vecs[i].exp_state);

`ifdef SP_ILLEGAL_OP_EN
    repeat (3) step("illegal_hold", 9'h000, 1'b0, '0, T0);
    checks++;
    if (illegal_op !== 1'b1) begin
      failures++;
      $display("FAIL illegal_op_sticky: got %b expected 1", illegal_op);
    end
`endif

    // reset during T2 of add R0,R1 aborts with no Done
    step("abort_t1", 9'b010_000_001, 1'b1, ex(8'h00, 8'h01, C_AIN), T1);
    step("abort_t2", 9'h000,         1'b0, ex(8'h00, 8'h02, C_GIN), T2);
    rst = 1'b1;
    step("abort_rst", 9'h000, 1'b1, '0, T0);
    rst = 1'b0;
    for (int i = 0; i < 3; i++)
      step($sformatf("abort_idle%0d", i), 9'h000, 1'b0, '0, T0);
`ifdef SP_ILLEGAL_OP_EN
    checks++;
    if (illegal_op !== 1'b0) begin
      failures++;
      $display("FAIL illegal_op_cleared: got %b expected 0", illegal_op);
    end
`endif

    // mv after reset uses the newly captured IR
    step("post_rst_mv",  9'b000_011_110, 1'b1, ex(8'h08, 8'h40, C_DONE), T1);
    step("post_rst_idle", 9'h000,        1'b0, '0, T0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
